// File: rtl/commit_checker.sv
// In-order retirement checker: compares each retired instruction against a preloaded
// expected-commit table. Optional macro CHK_CONTINUE_ON_ERR_EN keeps checking after a mismatch.
module commit_checker #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 64,
  parameter int TIMEOUT = 1024,
  parameter int IDX_W   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W:0]   n_expected,
  input  logic             ld_we,
  input  logic [IDX_W-1:0] ld_idx,
  input  logic [1:0]       ld_kind,
  input  logic [XLEN-1:0]  ld_pc,
  input  logic [XLEN-1:0]  ld_addr,
  input  logic [XLEN-1:0]  ld_data,
  input  logic             ret_valid,
  input  logic [XLEN-1:0]  ret_pc,
  input  logic             ret_rd_we,
  input  logic [4:0]       ret_rd,
  input  logic [XLEN-1:0]  ret_rd_data,
  input  logic             ret_mem_we,
  input  logic [XLEN-1:0]  ret_mem_addr,
  input  logic [XLEN-1:0]  ret_mem_wdata,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [IDX_W:0]   chk_count,
  output logic [IDX_W-1:0] fail_idx,
  output logic [XLEN-1:0]  fail_pc
);

`ifdef CHK_CONTINUE_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b0;
`else
  localparam bit STOP_ON_ERR = 1'b1;
`endif

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_PASS, S_FAIL, S_TIMEOUT
  } state_e;

  typedef enum logic [1:0] {
    K_NONE = 2'd0, K_REG = 2'd1, K_MEM = 2'd2, K_RSVD = 2'd3
  } kind_e;

  // NOTE: the table is plain storage with no reset, so it maps onto RAM and
  // keeps its contents across a reset, including one taken mid-run.
  logic [1:0]      tbl_kind [DEPTH];
  logic [XLEN-1:0] tbl_pc   [DEPTH];
  logic [XLEN-1:0] tbl_addr [DEPTH];
  logic [XLEN-1:0] tbl_data [DEPTH];

  state_e           state_q, state_d;
  logic [IDX_W:0]   chk_q, chk_d;
  logic [IDX_W:0]   nexp_q, nexp_d;
  logic [15:0]      err_q, err_d;
  logic [IDX_W-1:0] fidx_q, fidx_d;
  logic [XLEN-1:0]  fpc_q, fpc_d;
  logic [TO_W-1:0]  idle_q, idle_d;

  logic [IDX_W-1:0] rd_idx;
  kind_e            e_kind;
  logic [XLEN-1:0]  e_pc, e_addr, e_data;
  logic             rd_eff, entry_ok;

  always_ff @(posedge clk) begin
    if (ld_we && state_q != S_RUN) begin
      tbl_kind[ld_idx] <= ld_kind;
      tbl_pc[ld_idx]   <= ld_pc;
      tbl_addr[ld_idx] <= ld_addr;
      tbl_data[ld_idx] <= ld_data;
    end
  end

  assign rd_idx = chk_q[IDX_W-1:0];
  assign e_kind = kind_e'(tbl_kind[rd_idx]);
  assign e_pc   = tbl_pc[rd_idx];
  assign e_addr = tbl_addr[rd_idx];
  assign e_data = tbl_data[rd_idx];

  // A write to x0 is architecturally invisible, so it does not count as a write.
  assign rd_eff = ret_rd_we && (ret_rd != 5'd0);

  always_comb begin
    entry_ok = 1'b0;
    case (e_kind)
      K_REG:   entry_ok = rd_eff && (ret_rd == e_addr[4:0]) &&
                          (ret_rd_data == e_data) && !ret_mem_we;
      K_MEM:   entry_ok = ret_mem_we && (ret_mem_addr == e_addr) &&
                          (ret_mem_wdata == e_data) && !rd_eff;
      default: entry_ok = !rd_eff && !ret_mem_we;
    endcase
    entry_ok = entry_ok && (ret_pc == e_pc);
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path
    // leaves one unassigned, which would infer a latch.
    state_d = state_q;
    chk_d   = chk_q;
    nexp_d  = nexp_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    fpc_d   = fpc_q;
    idle_d  = idle_q;

    case (state_q)
      S_RUN: begin
        if (ret_valid) begin
          idle_d = '0;
          chk_d  = chk_q + 1'b1;
          if (!entry_ok) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (err_q == 16'd0) begin
              fidx_d = rd_idx;
              fpc_d  = ret_pc;
            end
          end
          if (!entry_ok && STOP_ON_ERR) state_d = S_FAIL;
          else if (chk_d == nexp_q)      state_d = (err_d == 16'd0) ? S_PASS : S_FAIL;
        end else if (idle_q == TO_LAST) begin
          state_d = S_TIMEOUT;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      default: begin
        if (start) begin
          state_d = (n_expected == '0) ? S_PASS : S_RUN;
          nexp_d  = n_expected;
          chk_d   = '0;
          err_d   = '0;
          fidx_d  = '0;
          fpc_d   = '0;
          idle_d  = '0;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the combinational blocks above use blocking ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      chk_q   <= '0;
      nexp_q  <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      fpc_q   <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      chk_q   <= chk_d;
      nexp_q  <= nexp_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fpc_q   <= fpc_d;
      idle_q  <= idle_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_PASS) || (state_q == S_FAIL) || (state_q == S_TIMEOUT);
  assign pass      = (state_q == S_PASS);
  assign err_count = err_q;
  assign chk_count = chk_q;
  assign fail_idx  = fidx_q;
  assign fail_pc   = fpc_q;

endmodule

// File: tb/tb_commit_checker.sv
// Self-checking bench for commit_checker: table-driven retire vectors with a
// scoreboard queue of expected counters, plus hand-written corner-case sequences.
module tb_commit_checker;
  localparam int XLEN = 32, DEPTH = 64, TIMEOUT = 1024, IDX_W = 6;
`ifdef CHK_CONTINUE_ON_ERR_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, start, ld_we, ret_valid, ret_rd_we, ret_mem_we;
  logic [IDX_W:0]   n_expected;
  logic [IDX_W-1:0] ld_idx;
  logic [1:0]       ld_kind;
  logic [XLEN-1:0]  ld_pc, ld_addr, ld_data;
  logic [XLEN-1:0]  ret_pc, ret_rd_data, ret_mem_addr, ret_mem_wdata;
  logic [4:0]       ret_rd;
  logic             busy, done, pass;
  logic [15:0]      err_count;
  logic [IDX_W:0]   chk_count;
  logic [IDX_W-1:0] fail_idx;
  logic [XLEN-1:0]  fail_pc;

  commit_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .n_expected(n_expected),
    .ld_we(ld_we), .ld_idx(ld_idx), .ld_kind(ld_kind), .ld_pc(ld_pc),
    .ld_addr(ld_addr), .ld_data(ld_data), .ret_valid(ret_valid),
    .ret_pc(ret_pc), .ret_rd_we(ret_rd_we), .ret_rd(ret_rd),
    .ret_rd_data(ret_rd_data), .ret_mem_we(ret_mem_we),
    .ret_mem_addr(ret_mem_addr), .ret_mem_wdata(ret_mem_wdata),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .chk_count(chk_count), .fail_idx(fail_idx), .fail_pc(fail_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        rd_we;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    bit          match;
  } ret_vec_t;

  typedef struct {
    int chk;
    int err;
  } exp_t;

  ret_vec_t vecs[8];
  exp_t     sb_q[$];
  int       n_checks = 0;
  int       n_fail   = 0;

  // Reference model of the checker's visible counters.
  int          m_n, m_chk, m_err, m_fidx;
  bit          m_run;
  logic [31:0] m_fpc;

  function automatic ret_vec_t mk(input logic [31:0] pc, input logic rd_we,
                                  input logic [4:0] rd, input logic [31:0] rd_data,
                                  input logic mem_we, input logic [31:0] mem_addr,
                                  input logic [31:0] mem_wdata, input bit match);
    ret_vec_t v;
    v.pc = pc; v.rd_we = rd_we; v.rd = rd; v.rd_data = rd_data;
    v.mem_we = mem_we; v.mem_addr = mem_addr; v.mem_wdata = mem_wdata;
    v.match = match;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [1:0] kind, input logic [31:0] pc,
                      input logic [31:0] addr, input logic [31:0] data);
    ld_we = 1'b1; ld_idx = IDX_W'(idx); ld_kind = kind;
    ld_pc = pc; ld_addr = addr; ld_data = data;
    tick();
    ld_we = 1'b0;
  endtask

  task automatic start_run(input int n);
    start = 1'b1; n_expected = (IDX_W+1)'(n);
    tick();
    start = 1'b0;
    m_n = n; m_chk = 0; m_err = 0; m_fidx = 0; m_fpc = '0; m_run = (n != 0);
  endtask

  task automatic retire(input ret_vec_t v);
    exp_t e;
    ret_valid = 1'b1; ret_pc = v.pc; ret_rd_we = v.rd_we; ret_rd = v.rd;
    ret_rd_data = v.rd_data; ret_mem_we = v.mem_we; ret_mem_addr = v.mem_addr;
    ret_mem_wdata = v.mem_wdata;
    if (m_run) begin
      if (!v.match) begin
        if (m_err == 0) begin m_fidx = m_chk; m_fpc = v.pc; end
        if (m_err < 16'hFFFF) m_err++;
      end
      m_chk++;
      if ((!v.match && !CONT) || m_chk == m_n) m_run = 1'b0;
    end
    e.chk = m_chk; e.err = m_err;
    sb_q.push_back(e);
    tick();
    ret_valid = 1'b0; ret_rd_we = 1'b0; ret_mem_we = 1'b0;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check("sb_chk_count", 64'(chk_count), 64'(e.chk));
      check("sb_err_count", 64'(err_count), 64'(e.err));
    end
  endtask

  task automatic check_verdict(input string tag);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_pass"}, 64'(pass), 64'(m_err == 0));
    check({tag, "_chk"},  64'(chk_count), 64'(m_chk));
    check({tag, "_err"},  64'(err_count), 64'(m_err));
    if (m_err != 0) begin
      check({tag, "_fail_idx"}, 64'(fail_idx), 64'(m_fidx));
      check({tag, "_fail_pc"},  64'(fail_pc),  64'(m_fpc));
    end
  endtask

  initial begin
    vecs[0] = mk(32'h0, 1'b1, 5'd18, 32'hABCDEF11, 1'b0, 32'h0,  32'h0,        1'b1);
    vecs[1] = mk(32'h4, 1'b0, 5'd0,  32'h0,        1'b1, 32'h10, 32'hABCDEF11, 1'b1);
    vecs[2] = mk(32'h8, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,  32'h0,        1'b1);
    vecs[3] = mk(32'hC, 1'b1, 5'd1,  32'h4C,       1'b0, 32'h0,  32'h0,        1'b1);
    vecs[4] = mk(32'h4, 1'b0, 5'd0,  32'h0,        1'b1, 32'h10, 32'h0,        1'b0);
    vecs[5] = mk(32'h40, 1'b1, 5'd0, 32'h1234,     1'b0, 32'h0,  32'h0,        1'b1);
    vecs[6] = mk(32'h44, 1'b1, 5'd5, 32'h1234,     1'b0, 32'h0,  32'h0,        1'b0);
    vecs[7] = vecs[0];

    rst = 1'b1; start = 1'b0; n_expected = '0; ld_we = 1'b0; ld_idx = '0;
    ld_kind = '0; ld_pc = '0; ld_addr = '0; ld_data = '0; ret_valid = 1'b0;
    ret_pc = '0; ret_rd_we = 1'b0; ret_rd = '0; ret_rd_data = '0;
    ret_mem_we = 1'b0; ret_mem_addr = '0; ret_mem_wdata = '0;
    m_n = 0; m_chk = 0; m_err = 0; m_fidx = 0; m_fpc = '0; m_run = 1'b0;

    repeat (2) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_err", 64'(err_count), 64'd0);
    check("rst_chk", 64'(chk_count), 64'd0);
    check("rst_fail_idx", 64'(fail_idx), 64'd0);
    check("rst_fail_pc", 64'(fail_pc), 64'd0);
    rst = 1'b0;
    tick();

    load(0, 2'd1, 32'h0, 32'd18, 32'hABCDEF11);
    load(1, 2'd2, 32'h4, 32'h10, 32'hABCDEF11);
    load(2, 2'd0, 32'h8, 32'h0,  32'h0);
    load(3, 2'd1, 32'hC, 32'd1,  32'h4C);

    // Exact program: all four entries match.
    start_run(4);
    check("run_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 4; i++) retire(vecs[i]);
    check_verdict("good");
    check("good_pass_abs", 64'(pass), 64'd1);

    // Entry 1 store data corrupted; trailing retires are ignored once stopped.
    start_run(4);
    retire(vecs[0]);
    retire(vecs[4]);
    retire(vecs[2]);
    retire(vecs[3]);
    check_verdict("corrupt");
    check("corrupt_fail_idx_abs", 64'(fail_idx), 64'd1);
    check("corrupt_fail_pc_abs", 64'(fail_pc), 64'h4);

    // Reset mid-run, then rerun from the surviving table.
    start_run(4);
    retire(vecs[0]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_err", 64'(err_count), 64'd0);
    check("midrst_chk", 64'(chk_count), 64'd0);
    start_run(4);
    for (int i = 0; i < 4; i++) retire(vecs[i]);
    check_verdict("rerun");

    // Zero-length run passes on the very next cycle.
    start_run(0);
    check("zero_pass", 64'(pass), 64'd1);
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);

    // Table writes while busy must be dropped.
    start_run(1);
    load(0, 2'd0, 32'h100, 32'h0, 32'h0);
    retire(vecs[7]);
    check_verdict("ldbusy");

    // x0 write counts as no write for a NONE entry; x5 write does not.
    load(0, 2'd0, 32'h40, 32'h0, 32'h0);
    load(1, 2'd0, 32'h44, 32'h0, 32'h0);
    start_run(2);
    retire(vecs[5]);
    retire(vecs[6]);
    check_verdict("x0");

    // No retirements: verdict exactly TIMEOUT cycles after start.
    start_run(4);
    repeat (TIMEOUT - 1) tick();
    check("to_early_done", 64'(done), 64'd0);
    check("to_early_busy", 64'(busy), 64'd1);
    tick();
    check("to_done", 64'(done), 64'd1);
    check("to_pass", 64'(pass), 64'd0);
    check("to_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
